fp_add_ctrl: RTL



---
 rtl/fp_add_ctrl_pkg.sv | 27 ++
 rtl/fp_add_ctrl_lzc.sv | 28 ++
 rtl/fp_add_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_add_ctrl_pkg.sv
// Shared definitions for the handshaked single-precision adder sequencer:
// default field widths, canonical quiet NaN, FSM encoding and the bit
// positions of the status flags.
package fp_add_ctrl_pkg;

    localparam int DEF_EXP_WIDTH = 8;
    localparam int DEF_SIG_WIDTH = 23;
    localparam int DEF_BIAS      = 127;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    // flags = {invalid, overflow, underflow, inexact}
    localparam int FLG_INVALID   = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_ROUND = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/fp_add_ctrl_lzc.sv
// fp_lzc: combinational leading-zero counter.
//   i_data  : value to scan (28 bits by default, the raw adder output)
//   o_count : number of zeros above the most significant set bit
//             (equals WIDTH when i_data is zero)
//   o_zero  : i_data is all zeros
module fp_lzc
    import fp_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_SIG_WIDTH + 5,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CW-1:0]    o_count,
    output logic             o_zero
);

    // Scanning upward means the last hit is the most significant one.
    always_comb begin
        o_count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) begin
                o_count = CW'(WIDTH - 1 - i);
            end
        end
        o_zero = ~|i_data;
    end

endmodule

// File: rtl/fp_add_ctrl.sv
// fp_add_ctrl: multi-cycle binary32 adder wrapped in valid/ready handshakes.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready, a, b, sub : operand pair (sub=1 computes a - b)
//   out_valid/out_ready, result, flags : packed sum and
//                           {invalid, overflow, underflow, inexact}
//
// state | meaning
// IDLE  | ready for operands
// ALIGN | unpack, resolve specials, order by magnitude, align smaller one
// ADD   | 28-bit magnitude add/subtract
// NORM  | carry right-shift or leading-zero left-shift
// ROUND | nearest-even rounding, overflow/underflow
// DONE  | result presented, held until out_ready
module fp_add_ctrl
    import fp_add_ctrl_pkg::*;
#(
    parameter int EXP_WIDTH = DEF_EXP_WIDTH,
    parameter int SIG_WIDTH = DEF_SIG_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [EXP_WIDTH+SIG_WIDTH:0]   a,
    input  logic [EXP_WIDTH+SIG_WIDTH:0]   b,
    input  logic                           sub,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [EXP_WIDTH+SIG_WIDTH:0]   result,
    output logic [3:0]                     flags
);

    localparam int TW  = EXP_WIDTH + SIG_WIDTH + 1;
    localparam int FW  = SIG_WIDTH + 4;         // {1.f, G, R, S}
    localparam int SW  = SIG_WIDTH + 5;         // FW plus carry
    localparam int EXW = EXP_WIDTH + 2;         // exponent with sign/overflow room
    localparam int CW  = $clog2(SW + 1);
    localparam logic [EXP_WIDTH-1:0] EXP_MAX = '1;

    state_t r_state, w_state_nxt;

    logic [TW-1:0]  r_a, r_b;
    logic           r_sign, r_eff_sub, r_out_valid;
    logic [EXW-1:0] r_exp;
    logic [FW-1:0]  r_sig_a, r_sig_b, r_norm;
    logic [SW-1:0]  r_sum;
    logic [TW-1:0]  r_result;
    logic [3:0]     r_flags;

    // ---------------- ALIGN: unpack and classify ----------------
    logic                 w_sa, w_sb;
    logic [EXP_WIDTH-1:0] w_ea, w_eb;
    logic [SIG_WIDTH-1:0] w_fa, w_fb;
    logic                 w_a_zero, w_b_zero, w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic [TW-2:0]        w_mag_a, w_mag_b;

    assign w_sa = r_a[TW-1];
    assign w_sb = r_b[TW-1];
    assign w_ea = r_a[TW-2 -: EXP_WIDTH];
    assign w_eb = r_b[TW-2 -: EXP_WIDTH];
    assign w_fa = r_a[SIG_WIDTH-1:0];
    assign w_fb = r_b[SIG_WIDTH-1:0];

    // Zero exponent covers subnormals too: they flush to signed zero.
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_nan  = (w_ea == EXP_MAX) && (w_fa != '0);
    assign w_b_nan  = (w_eb == EXP_MAX) && (w_fb != '0);
    assign w_a_inf  = (w_ea == EXP_MAX) && (w_fa == '0);
    assign w_b_inf  = (w_eb == EXP_MAX) && (w_fb == '0);
    assign w_mag_a  = w_a_zero ? '0 : r_a[TW-2:0];
    assign w_mag_b  = w_b_zero ? '0 : r_b[TW-2:0];

    logic          w_special;
    logic [TW-1:0] w_spec_result;
    logic [3:0]    w_spec_flags;

    always_comb begin
        w_special     = 1'b1;
        w_spec_result = '0;
        w_spec_flags  = '0;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb))) begin
            w_spec_result              = CANON_NAN;
            w_spec_flags[FLG_INVALID]  = 1'b1;
        end else if (w_a_inf) begin
            w_spec_result = {w_sa, EXP_MAX, {SIG_WIDTH{1'b0}}};
        end else if (w_b_inf) begin
            w_spec_result = {w_sb, EXP_MAX, {SIG_WIDTH{1'b0}}};
        end else if (w_a_zero && w_b_zero) begin
            w_spec_result = {w_sa & w_sb, {(TW-1){1'b0}}};
        end else begin
            w_special = 1'b0;
        end
    end

    logic                 w_swap, w_big_sign, w_small_zero;
    logic [EXP_WIDTH-1:0] w_big_exp, w_small_exp, w_exp_diff;
    logic [SIG_WIDTH:0]   w_sig_big, w_sig_small;
    logic [FW-1:0]        w_ext_small, w_shifted, w_lost, w_sig_b_al;

    assign w_swap       = (w_mag_b > w_mag_a);
    assign w_big_sign   = w_swap ? w_sb : w_sa;
    assign w_big_exp    = w_swap ? w_eb : w_ea;
    assign w_small_exp  = w_swap ? w_ea : w_eb;
    assign w_small_zero = w_swap ? w_a_zero : w_b_zero;
    assign w_sig_big    = w_swap ? {~w_b_zero, w_fb} : {~w_a_zero, w_fa};
    assign w_sig_small  = w_small_zero ? '0 : (w_swap ? {1'b1, w_fa} : {1'b1, w_fb});
    assign w_exp_diff   = w_big_exp - w_small_exp;
    assign w_ext_small  = {w_sig_small, 3'b000};

    // Right shift with everything shifted out past S folded into S.
    always_comb begin
        w_shifted  = '0;
        w_lost     = '0;
        w_sig_b_al = '0;
        if (w_exp_diff >= EXP_WIDTH'(FW)) begin
            w_sig_b_al = {{(FW-1){1'b0}}, |w_sig_small};
        end else begin
            w_shifted  = w_ext_small >> w_exp_diff;
            w_lost     = w_ext_small & ((FW'(1) << w_exp_diff) - FW'(1));
            w_sig_b_al = {w_shifted[FW-1:1], w_shifted[0] | (|w_lost)};
        end
    end

    // ---------------- NORM ----------------
    logic [CW-1:0]  w_lz, w_lsh;
    logic           w_lz_zero;
    logic [FW-1:0]  w_norm_field;
    logic [EXW-1:0] w_norm_exp;

    fp_lzc #(.WIDTH(SW), .CW(CW)) u_lzc (
        .i_data  (r_sum),
        .o_count (w_lz),
        .o_zero  (w_lz_zero)
    );

    // The hidden bit belongs at bit FW-1, one below the carry position,
    // so the left shift is one less than the raw leading-zero count.
    assign w_lsh = w_lz - CW'(1);

    always_comb begin
        if (r_sum[SW-1]) begin
            w_norm_field = {r_sum[SW-1:2], r_sum[1] | r_sum[0]};
            w_norm_exp   = r_exp + EXW'(1);
        end else begin
            w_norm_field = r_sum[FW-1:0] << w_lsh;
            w_norm_exp   = r_exp - EXW'(w_lsh);
        end
    end

    // ---------------- ROUND ----------------
    logic                 w_l, w_g, w_r, w_s, w_inc, w_mcarry;
    logic [SIG_WIDTH:0]   w_mant;
    logic [SIG_WIDTH-1:0] w_frac;
    logic [EXW-1:0]       w_rnd_exp;
    logic [TW-1:0]        w_rnd_result;
    logic [3:0]           w_rnd_flags;

    assign w_mant    = r_norm[FW-1:3];
    assign w_l       = r_norm[3];
    assign w_g       = r_norm[2];
    assign w_r       = r_norm[1];
    assign w_s       = r_norm[0];
    assign w_inc     = w_g & (w_r | w_s | w_l);
    // An all-ones mantissa that rounds up wraps the fraction to zero.
    assign w_mcarry  = w_inc & (&w_mant);
    assign w_frac    = w_mant[SIG_WIDTH-1:0] + SIG_WIDTH'(w_inc);
    assign w_rnd_exp = w_mcarry ? r_exp + EXW'(1) : r_exp;

    always_comb begin
        w_rnd_flags              = '0;
        w_rnd_flags[FLG_INEXACT] = w_g | w_r | w_s;
        // Sign bit of the widened exponent marks a negative value.
        if (!w_rnd_exp[EXW-1] && (w_rnd_exp >= EXW'(EXP_MAX))) begin
            w_rnd_result               = {r_sign, EXP_MAX, {SIG_WIDTH{1'b0}}};
            w_rnd_flags[FLG_OVERFLOW]  = 1'b1;
            w_rnd_flags[FLG_INEXACT]   = 1'b1;
        end else if (w_rnd_exp[EXW-1] || (w_rnd_exp == '0)) begin
            w_rnd_result               = {r_sign, {(TW-1){1'b0}}};
            w_rnd_flags[FLG_UNDERFLOW] = 1'b1;
            w_rnd_flags[FLG_INEXACT]   = 1'b1;
        end else begin
            w_rnd_result = {r_sign, w_rnd_exp[EXP_WIDTH-1:0], w_frac};
        end
    end

    // ---------------- FSM ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid) w_state_nxt = ST_ALIGN;
            ST_ALIGN: w_state_nxt = w_special ? ST_DONE : ST_ADD;
            ST_ADD:   w_state_nxt = ST_NORM;
            ST_NORM:  w_state_nxt = w_lz_zero ? ST_DONE : ST_ROUND;
            ST_ROUND: w_state_nxt = ST_DONE;
            ST_DONE:  if (r_out_valid && out_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // out_valid comes up one cycle after DONE is entered, from a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_out_valid <= !(r_out_valid && out_ready);
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_sign    <= 1'b0;
            r_eff_sub <= 1'b0;
            r_exp     <= '0;
            r_sig_a   <= '0;
            r_sig_b   <= '0;
            r_sum     <= '0;
            r_norm    <= '0;
            r_result  <= '0;
            r_flags   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a <= a;
                        r_b <= {b[TW-1] ^ sub, b[TW-2:0]};
                    end
                end
                ST_ALIGN: begin
                    if (w_special) begin
                        r_result <= w_spec_result;
                        r_flags  <= w_spec_flags;
                    end
                    r_sign    <= w_big_sign;
                    r_eff_sub <= w_sa ^ w_sb;
                    r_exp     <= EXW'(w_big_exp);
                    r_sig_a   <= {w_sig_big, 3'b000};
                    r_sig_b   <= w_sig_b_al;
                end
                ST_ADD: begin
                    r_sum <= r_eff_sub ? ({1'b0, r_sig_a} - {1'b0, r_sig_b})
                                       : ({1'b0, r_sig_a} + {1'b0, r_sig_b});
                end
                ST_NORM: begin
                    if (w_lz_zero) begin
                        r_result <= '0;
                        r_flags  <= '0;
                    end
                    r_norm <= w_norm_field;
                    r_exp  <= w_norm_exp;
                end
                ST_ROUND: begin
                    r_result <= w_rnd_result;
                    r_flags  <= w_rnd_flags;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;

endmodule
